// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: accepts one EXU request, checks opcode and alignment,
// issues one aligned bus transaction with byte mask, and returns extended
// load data with an error cause.
module lsu_mem_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [1:0]        resp_cause,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata,
  input  logic              mem_resp_err
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OffW = $clog2(NB);
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StMreq, StMwait, StResp} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [OffW-1:0]   off_q, off_d;
  logic              wen_q, wen_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_req_wen_q, mem_req_wen_d;
  logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [XLEN-1:0]   mem_req_wdata_q, mem_req_wdata_d;
  logic [NB-1:0]     mem_req_wmask_q, mem_req_wmask_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic [1:0]        resp_cause_q, resp_cause_d;

  logic [OffW-1:0]   req_off;
  logic              illegal, misaligned;
  logic [7:0]        base_mask;
  logic [NB-1:0]     fmt_mask;
  logic [XLEN-1:0]   fmt_wdata;
  logic [ADDR_W-1:0] fmt_addr;
  logic [XLEN-1:0]   ld_sh, ld_data;
  logic              ld_sgn;

  assign req_off = req_addr[OffW-1:0];

  // Request decode: opcode legality, alignment and store formatting
  always_comb begin
    illegal = (req_op == 3'd7);
    if (XLEN == 32) begin
      if (req_wen) illegal = illegal | (req_op >= 3'd3);
      else         illegal = illegal | (req_op == 3'd3) | (req_op == 3'd6);
    end else if (req_wen) begin
      illegal = illegal | (req_op >= 3'd4);
    end
    unique case (req_op[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
    unique case (req_op[1:0])
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
    fmt_mask  = NB'(base_mask) << req_off;
    fmt_wdata = req_wdata << {req_off, 3'b000};
    fmt_addr  = req_addr & ~ADDR_W'(NB - 1);
  end

  // Load data: shift the addressed bytes down, then sign/zero extend
  always_comb begin
    ld_sh  = mem_resp_rdata >> {off_q, 3'b000};
    ld_sgn = ~op_q[2];
    unique case (op_q[1:0])
      2'd0:    ld_data = ld_sgn ? XLEN'($signed(ld_sh[7:0]))  : XLEN'(ld_sh[7:0]);
      2'd1:    ld_data = ld_sgn ? XLEN'($signed(ld_sh[15:0])) : XLEN'(ld_sh[15:0]);
      2'd2:    ld_data = ld_sgn ? XLEN'($signed(ld_sh[31:0])) : XLEN'(ld_sh[31:0]);
      default: ld_data = ld_sh;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    off_d           = off_q;
    wen_d           = wen_q;
    cnt_d           = cnt_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_wen_d   = mem_req_wen_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_wdata_d = mem_req_wdata_q;
    mem_req_wmask_d = mem_req_wmask_q;
    resp_valid_d    = resp_valid_q;
    resp_rdata_d    = resp_rdata_q;
    resp_cause_d    = resp_cause_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          op_d            = req_op;
          off_d           = req_off;
          wen_d           = req_wen;
          mem_req_wen_d   = req_wen;
          mem_req_addr_d  = fmt_addr;
          mem_req_wdata_d = fmt_wdata;
          mem_req_wmask_d = req_wen ? fmt_mask : '0;
          resp_rdata_d    = '0;
          resp_cause_d    = 2'd0;
          if (illegal) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_cause_d = 2'd2;
          end else if (misaligned) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_cause_d = 2'd1;
          end else begin
            state_d         = StMreq;
            mem_req_valid_d = 1'b1;
          end
        end
      end
      StMreq: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          cnt_d           = '0;
          state_d         = StMwait;
        end
      end
      StMwait: begin
        if (mem_resp_valid) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          if (mem_resp_err) begin
            resp_cause_d = 2'd3;
            resp_rdata_d = '0;
          end else begin
            resp_cause_d = 2'd0;
            resp_rdata_d = wen_q ? '0 : ld_data;
          end
        end else if (TIMEOUT > 0) begin
          if (cnt_q != CntW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntW'(TIMEOUT)) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_cause_d = 2'd3;
            resp_rdata_d = '0;
          end
        end
      end
      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; everything clears on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      op_q            <= '0;
      off_q           <= '0;
      wen_q           <= 1'b0;
      cnt_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_wen_q   <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      mem_req_wmask_q <= '0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_cause_q    <= '0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      off_q           <= off_d;
      wen_q           <= wen_d;
      cnt_q           <= cnt_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_wen_q   <= mem_req_wen_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      mem_req_wmask_q <= mem_req_wmask_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_cause_q    <= resp_cause_d;
    end
  end

  // rst_n gates req_ready so it reads 0 throughout reset
  assign req_ready     = rst_n && (state_q == StIdle);
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_wen   = mem_req_wen_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign mem_req_wmask = mem_req_wmask_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_cause    = resp_cause_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a 32-bit instance without timeout and a
// 64-bit instance with TIMEOUT=8, checked against hand-computed values.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // 32-bit instance signals
  logic        rst32_n;
  logic        r32_valid, r32_ready, r32_wen;
  logic [2:0]  r32_op;
  logic [31:0] r32_addr, r32_wdata;
  logic        p32_valid, p32_ready;
  logic [31:0] p32_rdata;
  logic [1:0]  p32_cause;
  logic        m32_req_valid, m32_req_ready, m32_wen;
  logic [31:0] m32_addr, m32_wdata;
  logic [3:0]  m32_wmask;
  logic        m32_resp_valid, m32_resp_err;
  logic [31:0] m32_resp_rdata;

  // 64-bit instance signals
  logic        rst64_n;
  logic        r64_valid, r64_ready, r64_wen;
  logic [2:0]  r64_op;
  logic [31:0] r64_addr;
  logic [63:0] r64_wdata;
  logic        p64_valid, p64_ready;
  logic [63:0] p64_rdata;
  logic [1:0]  p64_cause;
  logic        m64_req_valid, m64_req_ready, m64_wen;
  logic [31:0] m64_addr;
  logic [63:0] m64_wdata;
  logic [7:0]  m64_wmask;
  logic        m64_resp_valid, m64_resp_err;
  logic [63:0] m64_resp_rdata;

  lsu_mem_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT(0)) u_dut32 (
    .clk(clk), .rst_n(rst32_n),
    .req_valid(r32_valid), .req_ready(r32_ready), .req_wen(r32_wen), .req_op(r32_op),
    .req_addr(r32_addr), .req_wdata(r32_wdata),
    .resp_valid(p32_valid), .resp_ready(p32_ready), .resp_rdata(p32_rdata),
    .resp_cause(p32_cause),
    .mem_req_valid(m32_req_valid), .mem_req_ready(m32_req_ready), .mem_req_wen(m32_wen),
    .mem_req_addr(m32_addr), .mem_req_wdata(m32_wdata), .mem_req_wmask(m32_wmask),
    .mem_resp_valid(m32_resp_valid), .mem_resp_rdata(m32_resp_rdata),
    .mem_resp_err(m32_resp_err)
  );

  lsu_mem_ctrl #(.XLEN(64), .ADDR_W(32), .TIMEOUT(8)) u_dut64 (
    .clk(clk), .rst_n(rst64_n),
    .req_valid(r64_valid), .req_ready(r64_ready), .req_wen(r64_wen), .req_op(r64_op),
    .req_addr(r64_addr), .req_wdata(r64_wdata),
    .resp_valid(p64_valid), .resp_ready(p64_ready), .resp_rdata(p64_rdata),
    .resp_cause(p64_cause),
    .mem_req_valid(m64_req_valid), .mem_req_ready(m64_req_ready), .mem_req_wen(m64_wen),
    .mem_req_addr(m64_addr), .mem_req_wdata(m64_wdata), .mem_req_wmask(m64_wmask),
    .mem_resp_valid(m64_resp_valid), .mem_resp_rdata(m64_resp_rdata),
    .mem_resp_err(m64_resp_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full bus transaction on the 32-bit unit with immediate ready/response
  task automatic txn32(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] bus,
                       input logic [31:0] e_addr, input logic [31:0] e_wdata,
                       input logic [3:0] e_mask, input logic [31:0] e_rdata);
    @(negedge clk);
    r32_valid = 1'b1; r32_wen = wen; r32_op = op; r32_addr = addr; r32_wdata = wdata;
    check("t32_req_ready", r32_ready, 1);
    @(negedge clk);
    r32_valid = 1'b0;
    check("t32_mreq_valid", m32_req_valid, 1);
    check("t32_mreq_addr", m32_addr, e_addr);
    check("t32_mreq_wmask", m32_wmask, e_mask);
    check("t32_mreq_wen", m32_wen, wen);
    if (wen) check("t32_mreq_wdata", m32_wdata, e_wdata);
    check("t32_busy", r32_ready, 0);
    @(negedge clk);
    check("t32_mreq_drop", m32_req_valid, 0);
    check("t32_no_early_resp", p32_valid, 0);
    m32_resp_valid = 1'b1; m32_resp_rdata = bus;
    @(negedge clk);
    m32_resp_valid = 1'b0;
    check("t32_resp_valid", p32_valid, 1);
    check("t32_resp_rdata", p32_rdata, e_rdata);
    check("t32_resp_cause", p32_cause, 0);
    @(negedge clk);
    check("t32_resp_done", p32_valid, 0);
    check("t32_ready_again", r32_ready, 1);
  endtask

  // Rejected request on the 32-bit unit: response one cycle after acceptance
  task automatic err32(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                       input logic [1:0] e_cause);
    @(negedge clk);
    r32_valid = 1'b1; r32_wen = wen; r32_op = op; r32_addr = addr; r32_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    r32_valid = 1'b0;
    check("e32_resp_valid", p32_valid, 1);
    check("e32_cause", p32_cause, e_cause);
    check("e32_rdata", p32_rdata, 0);
    check("e32_no_bus", m32_req_valid, 0);
    @(negedge clk);
    check("e32_resp_done", p32_valid, 0);
    check("e32_no_bus_after", m32_req_valid, 0);
    check("e32_ready_again", r32_ready, 1);
  endtask

  // Rejected request on the 64-bit unit
  task automatic err64(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                       input logic [1:0] e_cause);
    @(negedge clk);
    r64_valid = 1'b1; r64_wen = wen; r64_op = op; r64_addr = addr;
    @(negedge clk);
    r64_valid = 1'b0;
    check("e64_resp_valid", p64_valid, 1);
    check("e64_cause", p64_cause, e_cause);
    check("e64_no_bus", m64_req_valid, 0);
    @(negedge clk);
    check("e64_resp_done", p64_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst32_n = 1'b0; rst64_n = 1'b0;
    r32_valid = 0; r32_wen = 0; r32_op = 0; r32_addr = 0; r32_wdata = 0; p32_ready = 1;
    m32_req_ready = 1; m32_resp_valid = 0; m32_resp_err = 0; m32_resp_rdata = 0;
    r64_valid = 0; r64_wen = 0; r64_op = 0; r64_addr = 0; r64_wdata = 0; p64_ready = 1;
    m64_req_ready = 1; m64_resp_valid = 0; m64_resp_err = 0; m64_resp_rdata = 0;

    repeat (2) @(negedge clk);
    check("rst_req_ready32", r32_ready, 0);
    check("rst_mreq_valid32", m32_req_valid, 0);
    check("rst_resp_valid32", p32_valid, 0);
    check("rst_req_ready64", r64_ready, 0);
    rst32_n = 1'b1; rst64_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready32", r32_ready, 1);
    check("idle_req_ready64", r64_ready, 1);

    // lb at offset 3 sign-extends 0x80
    txn32(1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'h80FF_1234,
          32'h8000_0000, 32'h0, 4'h0, 32'hFFFF_FF80);
    // lbu at offset 2 zero-extends 0xFF
    txn32(1'b0, 3'd4, 32'h8000_0002, 32'h0, 32'h80FF_1234,
          32'h8000_0000, 32'h0, 4'h0, 32'h0000_00FF);
    // sh at offset 2: mask 0xC, data shifted 16
    txn32(1'b1, 3'd1, 32'h8000_0002, 32'hDEAD_BEEF, 32'h1234_5678,
          32'h8000_0000, 32'hBEEF_0000, 4'hC, 32'h0);

    err32(1'b0, 3'd2, 32'h8000_0006, 2'd1);  // lw misaligned
    err32(1'b0, 3'd7, 32'h8000_0006, 2'd2);  // op 7 beats misaligned
    err32(1'b0, 3'd1, 32'h8000_0001, 2'd1);  // lh misaligned
    err32(1'b0, 3'd3, 32'h8000_0000, 2'd2);  // ld on XLEN=32
    err32(1'b0, 3'd6, 32'h8000_0000, 2'd2);  // lwu on XLEN=32
    err32(1'b1, 3'd3, 32'h8000_0000, 2'd2);  // sd on XLEN=32

    // Bus back-pressure and slow response: everything must hold still
    m32_req_ready = 1'b0;
    @(negedge clk);
    r32_valid = 1'b1; r32_wen = 1'b0; r32_op = 3'd1; r32_addr = 32'h8000_0002;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      r32_valid = 1'b0;
      check("st_mreq_valid", m32_req_valid, 1);
      check("st_mreq_addr", m32_addr, 32'h8000_0000);
      check("st_mreq_wmask", m32_wmask, 0);
      check("st_mreq_wen", m32_wen, 0);
      check("st_req_ready", r32_ready, 0);
    end
    m32_req_ready = 1'b1;
    p32_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("st_wait_mreq", m32_req_valid, 0);
      check("st_wait_resp", p32_valid, 0);
      check("st_wait_ready", r32_ready, 0);
    end
    m32_resp_valid = 1'b1; m32_resp_rdata = 32'h8001_0000;
    @(negedge clk);
    m32_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("st_resp_valid", p32_valid, 1);
      check("st_resp_rdata", p32_rdata, 32'hFFFF_8001);
      check("st_resp_cause", p32_cause, 0);
      check("st_resp_ready", r32_ready, 0);
      if (i < 2) @(negedge clk);
    end
    p32_ready = 1'b1;
    @(negedge clk);
    check("st_resp_done", p32_valid, 0);
    check("st_ready_again", r32_ready, 1);

    // XLEN=64 lwu at offset 4 zero-extends the upper word
    @(negedge clk);
    r64_valid = 1'b1; r64_wen = 1'b0; r64_op = 3'd6; r64_addr = 32'h8000_0004;
    @(negedge clk);
    r64_valid = 1'b0;
    check("w64_mreq_valid", m64_req_valid, 1);
    check("w64_mreq_addr", m64_addr, 32'h8000_0000);
    check("w64_mreq_wmask", m64_wmask, 0);
    @(negedge clk);
    m64_resp_valid = 1'b1; m64_resp_rdata = 64'h8000_0001_1234_5678;
    @(negedge clk);
    m64_resp_valid = 1'b0;
    check("w64_resp_valid", p64_valid, 1);
    check("w64_resp_rdata", p64_rdata, 64'h0000_0000_8000_0001);
    check("w64_resp_cause", p64_cause, 0);
    @(negedge clk);
    check("w64_resp_done", p64_valid, 0);

    err64(1'b0, 3'd3, 32'h8000_0004, 2'd1);  // ld misaligned
    err64(1'b1, 3'd4, 32'h8000_0000, 2'd2);  // store op 4 illegal

    // Timeout: no bus response, cause 3 after 8 cycles in MWAIT
    @(negedge clk);
    r64_valid = 1'b1; r64_wen = 1'b0; r64_op = 3'd2; r64_addr = 32'h8000_0000;
    @(negedge clk);
    r64_valid = 1'b0;
    check("to_mreq_valid", m64_req_valid, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("to_no_resp_yet", p64_valid, 0);
    end
    @(negedge clk);
    check("to_resp_valid", p64_valid, 1);
    check("to_resp_cause", p64_cause, 3);
    check("to_resp_rdata", p64_rdata, 0);
    @(negedge clk);
    check("to_resp_done", p64_valid, 0);

    // Reset during MWAIT abandons the store; late bus response is ignored
    @(negedge clk);
    r64_valid = 1'b1; r64_wen = 1'b1; r64_op = 3'd3; r64_addr = 32'h8000_0010;
    r64_wdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    r64_valid = 1'b0;
    check("rs_mreq_wmask", m64_wmask, 8'hFF);
    check("rs_mreq_wdata", m64_wdata, 64'h1122_3344_5566_7788);
    check("rs_mreq_addr", m64_addr, 32'h8000_0010);
    check("rs_mreq_wen", m64_wen, 1);
    @(negedge clk);
    check("rs_in_mwait", m64_req_valid, 0);
    #1 rst64_n = 1'b0;
    #1;
    check("rs_req_ready", r64_ready, 0);
    check("rs_mreq_valid", m64_req_valid, 0);
    check("rs_mreq_wen0", m64_wen, 0);
    check("rs_mreq_addr0", m64_addr, 0);
    check("rs_mreq_wdata0", m64_wdata, 0);
    check("rs_mreq_wmask0", m64_wmask, 0);
    check("rs_resp_valid", p64_valid, 0);
    check("rs_resp_rdata", p64_rdata, 0);
    check("rs_resp_cause", p64_cause, 0);
    @(negedge clk);
    rst64_n = 1'b1;
    m64_resp_valid = 1'b1; m64_resp_rdata = 64'hFFFF;
    @(negedge clk);
    m64_resp_valid = 1'b0;
    check("rs_late_resp", p64_valid, 0);
    check("rs_idle_ready", r64_ready, 1);
    @(negedge clk);
    check("rs_late_resp2", p64_valid, 0);
    check("rs_no_bus", m64_req_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
